// File: rtl/proc_trace_capture.sv
// rtl/proc_trace_capture.sv - instruction trace recorder with circular buffer, halt stop and drain port
// Optional feature macro: TRACE_TIMESTAMP_EN (prepends a free-running cycle timestamp to each record)
module proc_trace_capture #(
  parameter int PC_W = 7,
  parameter int IR_W = 16,
  parameter int ST_W = 4,
  parameter int DEPTH = 16,
  parameter logic [ST_W-1:0] DECODE_ST = 4'h2,
  parameter logic [IR_W-1:0] HALT_IR = 16'h5000,
  parameter int TS_W = 16,
  localparam int REC_W = PC_W + IR_W
`ifdef TRACE_TIMESTAMP_EN
                         + TS_W
`endif
  ,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [PC_W-1:0]  PC_In,
  input  logic [IR_W-1:0]  IR_In,
  input  logic [ST_W-1:0]  State_In,
  input  logic             Arm,
  input  logic             Rd_En,
  output logic [REC_W-1:0] Rd_Data,
  output logic             Rd_Valid,
  output logic [CW-1:0]    Count,
  output logic             Wrapped,
  output logic             Halted,
  output logic             Busy
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_bad_param
    $error("proc_trace_capture: DEPTH must be a power of 2 >= 2 and TS_W >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             dec_q;
  logic             dec_now, cap, pop, full, is_halt;
  logic [REC_W-1:0] rec;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge Clk) begin
    if (!Reset || Arm) ts_q <= '0;
    else               ts_q <= ts_q + TS_W'(1);
  end

  assign rec = {ts_q, PC_In, IR_In};
`else
  assign rec = {PC_In, IR_In};
`endif

  // Only the first cycle of a decode state counts, so stalls in decode log once.
  assign dec_now = (State_In == DECODE_ST);
  assign cap     = (state_q == S_ARMED) && dec_now && !dec_q && !Arm;
  assign is_halt = (IR_In == HALT_IR);
  assign full    = (Count == CW'(DEPTH));
  assign pop     = (state_q == S_DONE) && Rd_En && (Count != '0) && !Arm;
  assign Busy    = (state_q == S_ARMED);

  always_comb begin
    state_d = state_q;
    if (Arm)                 state_d = S_ARMED;
    else if (cap && is_halt) state_d = S_DONE;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset && cap) mem[wr_ptr] <= rec;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Wrapped  <= 1'b0;
      Halted   <= 1'b0;
      Rd_Data  <= '0;
      Rd_Valid <= 1'b0;
      dec_q    <= 1'b0;
    end else begin
      dec_q    <= dec_now;
      Rd_Valid <= 1'b0;
      if (Arm) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        Count   <= '0;
        Wrapped <= 1'b0;
        Halted  <= 1'b0;
        Rd_Data <= '0;
      end else begin
        if (cap) begin
          wr_ptr <= wr_ptr + AW'(1);
          // When full the write lands on the oldest entry, so the read side slides forward.
          if (full) begin
            rd_ptr  <= rd_ptr + AW'(1);
            Wrapped <= 1'b1;
          end else begin
            Count <= Count + CW'(1);
          end
          if (is_halt) Halted <= 1'b1;
        end
        if (pop) begin
          Rd_Data  <= mem[rd_ptr];
          Rd_Valid <= 1'b1;
          rd_ptr   <= rd_ptr + AW'(1);
          Count    <= Count - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_proc_trace_capture.sv
// tb/tb_proc_trace_capture.sv - scoreboard bench for proc_trace_capture (default build)
module tb_proc_trace_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  pc_in;
  logic [15:0] ir_in;
  logic [3:0]  state_in;
  logic        arm;
  logic        rd_en;
  logic [22:0] rd_data;
  logic        rd_valid;
  logic [4:0]  count;
  logic        wrapped;
  logic        halted;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  int mode = 0;
  logic [22:0] model[$];
  logic [22:0] exp_q[$];
  logic [22:0] exp_rec;

  always #5 clk = ~clk;

  proc_trace_capture dut (
    .Clk(clk), .Reset(reset), .PC_In(pc_in), .IR_In(ir_in), .State_In(state_in),
    .Arm(arm), .Rd_En(rd_en), .Rd_Data(rd_data), .Rd_Valid(rd_valid),
    .Count(count), .Wrapped(wrapped), .Halted(halted), .Busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every Rd_Valid must match the oldest outstanding expected record.
  initial forever begin
    @(negedge clk);
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rd_valid: got data %0h expected no pop", rd_data);
      end else begin
        exp_rec = exp_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(exp_rec));
      end
    end
  end

  task automatic do_arm();
    @(negedge clk) arm = 1'b1;
    model.delete();
    mode = 1;
    @(negedge clk) arm = 1'b0;
  endtask

  task automatic instr(input logic [6:0] pc, input logic [15:0] ir);
    @(negedge clk) state_in = 4'h1;
    @(negedge clk) begin
      state_in = 4'h2;
      pc_in = pc;
      ir_in = ir;
    end
    if (mode == 1) begin
      if (model.size() == 16) void'(model.pop_front());
      model.push_back({pc, ir});
      if (ir == 16'h5000) mode = 2;
    end
    @(negedge clk) state_in = 4'h0;
  endtask

  task automatic pop_one();
    @(negedge clk) rd_en = 1'b1;
    if (mode == 2 && model.size() > 0) exp_q.push_back(model.pop_front());
    @(negedge clk) rd_en = 1'b0;
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b0; pc_in = '0; ir_in = '0; state_in = '0; arm = 1'b0; rd_en = 1'b0;
    // T1 reset
    repeat (2) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_wrapped", wrapped, 0);
    reset = 1'b1;

    // T2 short program ending in halt
    do_arm();
    chk("t2_busy", busy, 1);
    instr(7'h00, 16'h1100);
    instr(7'h01, 16'h1201);
    pop_one();
    chk("t2_read_ignored_armed", count, 2);
    instr(7'h02, 16'h1302);
    instr(7'h03, 16'h1403);
    instr(7'h04, 16'h5000);
    chk("t2_halted", halted, 1);
    chk("t2_busy_done", busy, 0);
    chk("t2_count", count, 5);
    chk("t2_wrapped", wrapped, 0);
    repeat (5) pop_one();
    drain_wait();
    chk("t2_count_empty", count, 0);
    chk("t2_last_data", rd_data, {7'h04, 16'h5000});
    pop_one();
    drain_wait();

    // T3 overflow then halt
    do_arm();
    chk("t3_halted_clr", halted, 0);
    chk("t3_count_clr", count, 0);
    for (int i = 0; i < 20; i++) instr(7'(i), 16'h0100 + 16'(i));
    chk("t3_count_full", count, 16);
    chk("t3_wrapped", wrapped, 1);
    chk("t3_not_halted", halted, 0);
    instr(7'd20, 16'h5000);
    chk("t3_count_halt", count, 16);
    chk("t3_halted", halted, 1);
    chk("t3_first_expect", 32'(model[0]), 32'({7'd5, 16'h0105}));
    repeat (16) pop_one();
    drain_wait();
    chk("t3_count_empty", count, 0);
    do_arm();
    chk("t3_wrapped_clr", wrapped, 0);

    // T4 decode state held three cycles gives one record
    @(negedge clk) state_in = 4'h1;
    @(negedge clk) begin state_in = 4'h2; pc_in = 7'h33; ir_in = 16'h7777; end
    model.push_back({7'h33, 16'h7777});
    repeat (2) @(negedge clk);
    @(negedge clk) state_in = 4'h0;
    chk("t4_one_record", count, 1);
    instr(7'h34, 16'h5000);
    chk("t4_count", count, 2);
    repeat (2) pop_one();
    drain_wait();

    // T5 reset mid-capture
    do_arm();
    instr(7'h10, 16'h2222);
    instr(7'h11, 16'h2333);
    instr(7'h12, 16'h2444);
    chk("t5_count3", count, 3);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    model.delete();
    mode = 0;
    chk("t5_count", count, 0);
    chk("t5_busy", busy, 0);
    chk("t5_halted", halted, 0);
    chk("t5_wrapped", wrapped, 0);
    chk("t5_rd_valid", rd_valid, 0);
    chk("t5_rd_data", rd_data, 0);
    instr(7'h13, 16'h1111);
    chk("t5_idle_ignored", count, 0);
    do_arm();
    instr(7'h20, 16'h5000);
    chk("t5_count1", count, 1);
    chk("t5_halted1", halted, 1);
    pop_one();
    drain_wait();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
